// File: rtl/dmem_arbiter.sv
// Two-port request/grant arbiter sharing the data memory between the core and a debug/loader port.
// Optional feature: define ARB_STARVE_GUARD_EN to let a starving core break a debug lock.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    LAST_CORE  = 2'd0,
    LAST_DBG   = 2'd1,
    DBG_LOCKED = 2'd2
  } st_t;

  st_t st_q, st_d;

  logic core_prio;
  logic core_sel;
  logic dbg_sel;

  logic              core_rvalid_q, core_rvalid_d;
  logic [DATA_W-1:0] core_rdata_q,  core_rdata_d;
  logic              dbg_rvalid_q,  dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q,   dbg_rdata_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starve_hit;

  assign starve_hit = (starve_q == STARVE_W'(STARVE_MAX));
`endif

  // Grant selection; rst masks grants so nothing reaches memory during reset.
  always_comb begin
    core_prio = (st_q == LAST_DBG);
`ifdef ARB_STARVE_GUARD_EN
    if (starve_hit) begin
      core_prio = 1'b1;
    end else begin
      core_prio = (st_q == LAST_DBG);
    end
`endif
    core_sel = !rst && core_req && (!dbg_req || core_prio);
    dbg_sel  = !rst && dbg_req && !core_sel;
  end

  always_comb begin
    st_d = st_q;
    if (core_sel) begin
      st_d = LAST_CORE;
    end else if (dbg_sel) begin
      st_d = dbg_lock ? DBG_LOCKED : LAST_DBG;
    end else begin
      case (st_q)
        DBG_LOCKED: st_d = LAST_DBG;
        LAST_CORE:  st_d = (!dbg_req || !dbg_lock) ? LAST_DBG : LAST_CORE;
        LAST_DBG:   st_d = LAST_DBG;
        default:    st_d = LAST_DBG;
      endcase
    end
  end

  // Read capture: data is latched only on a granted read and held otherwise.
  always_comb begin
    core_rvalid_d = core_sel && !core_we;
    dbg_rvalid_d  = dbg_sel && !dbg_we;
    core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
    dbg_rdata_d   = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
  end

`ifdef ARB_STARVE_GUARD_EN
  always_comb begin
    if (core_sel || !core_req) begin
      starve_d = '0;
    end else if (starve_hit) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q          <= LAST_DBG;
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rvalid_q  <= 1'b0;
      dbg_rdata_q   <= '0;
    end else begin
      st_q          <= st_d;
      core_rvalid_q <= core_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      dbg_rdata_q   <= dbg_rdata_d;
    end
  end

  assign core_gnt    = core_sel;
  assign dbg_gnt     = dbg_sel;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign dbg_rdata   = dbg_rdata_q;

  assign mem_we    = (core_sel && core_we) || (dbg_sel && dbg_we);
  assign mem_addr  = dbg_sel ? dbg_addr : core_addr;
  assign mem_wdata = dbg_sel ? dbg_wdata : core_wdata;

endmodule
